// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: game states, directions, coordinate width.
package snake_pkg;

  localparam int BIT = 10;

  typedef enum logic [1:0] {
    GS_IDLE = 2'b00,
    GS_PLAY = 2'b01,
    GS_OVER = 2'b11
  } game_state_e;

  typedef enum logic [2:0] {
    DIR_IDLE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

  function automatic dir_e reverse_dir(input dir_e d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return DIR_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/snake_game_ctrl_btn_sync.sv
// Two-flop synchroniser for a bank of raw buttons, with a rising-edge strobe per bit.
module snake_game_ctrl_btn_sync #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] btn_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Game sequencer for the snake datapath: state machine, movement strobe, direction and score.
//   state   | meaning
//   GS_IDLE | waiting for a start press; direction idle
//   GS_PLAY | game running; frames counted, collisions and fruit evaluated at frame_tick
//   GS_OVER | collision seen; direction idle, held for HOLD_FRAMES frames then back to idle
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int SPEED       = 8,
  parameter int HOLD_FRAMES = 120,
  parameter int SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               pixel_valid,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_start,
  input  logic               head_active,
  input  logic               body_active,
  input  logic               border_active,
  input  logic               fruit_active,
  output logic [1:0]         game_state,
  output logic [2:0]         direction,
  output logic               update,
  output logic               eat,
  output logic [SCORE_W-1:0] score
);

  localparam logic [7:0] FRAME_LAST = 8'(SPEED - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);

  // bit order: 0 start, 1 up, 2 down, 3 left, 4 right
  logic [4:0] btn_lvl;
  logic [4:0] btn_rise;
  logic       start_rise;
  logic       unused_btn;

  snake_game_ctrl_btn_sync #(.W(5)) u_btn_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  ({btn_right, btn_left, btn_down, btn_up, btn_start}),
    .sync_o (btn_lvl),
    .rise_o (btn_rise)
  );

  assign start_rise = btn_rise[0];
  assign unused_btn = ^{btn_rise[4:1], btn_lvl[0]};

  game_state_e        state_q;
  dir_e               dir_q;
  dir_e               pending_q;
  dir_e               pending_d;
  dir_e               btn_req;
  logic [7:0]         frame_cnt_q;
  logic [7:0]         hold_cnt_q;
  logic               hit_body_q;
  logic               hit_wall_q;
  logic               hit_fruit_q;
  logic               update_q;
  logic               eat_q;
  logic [SCORE_W-1:0] score_q;
  logic               sample_en;

  always_comb begin
    btn_req = DIR_IDLE;
    if (btn_lvl[1])      btn_req = DIR_UP;
    else if (btn_lvl[2]) btn_req = DIR_DOWN;
    else if (btn_lvl[3]) btn_req = DIR_LEFT;
    else if (btn_lvl[4]) btn_req = DIR_RIGHT;
  end

  always_comb begin
    pending_d = pending_q;
    if (btn_req != DIR_IDLE && btn_req != reverse_dir(dir_q)) pending_d = btn_req;
  end

  // While stationary the body sits on the head, so overlap is meaningless until the snake moves.
  assign sample_en = pixel_valid && (state_q == GS_PLAY) && (dir_q != DIR_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= GS_IDLE;
      dir_q       <= DIR_IDLE;
      pending_q   <= DIR_IDLE;
      frame_cnt_q <= '0;
      hold_cnt_q  <= '0;
      hit_body_q  <= 1'b0;
      hit_wall_q  <= 1'b0;
      hit_fruit_q <= 1'b0;
      update_q    <= 1'b0;
      eat_q       <= 1'b0;
      score_q     <= '0;
    end else begin
      update_q <= 1'b0;
      eat_q    <= 1'b0;
      case (state_q)
        GS_IDLE: begin
          dir_q       <= DIR_IDLE;
          hit_body_q  <= 1'b0;
          hit_wall_q  <= 1'b0;
          hit_fruit_q <= 1'b0;
          if (start_rise) begin
            state_q     <= GS_PLAY;
            frame_cnt_q <= '0;
            score_q     <= '0;
            pending_q   <= DIR_IDLE;
          end
        end

        GS_PLAY: begin
          pending_q <= pending_d;
          if (frame_tick) begin
            hit_body_q  <= 1'b0;
            hit_wall_q  <= 1'b0;
            hit_fruit_q <= 1'b0;
            if (hit_body_q || hit_wall_q) begin
              state_q    <= GS_OVER;
              dir_q      <= DIR_IDLE;
              hold_cnt_q <= HOLD_LAST;
            end else begin
              dir_q <= pending_q;
              if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_q <= '0;
                update_q    <= 1'b1;
              end else begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
              end
              if (hit_fruit_q) begin
                eat_q <= 1'b1;
                if (score_q != '1) score_q <= score_q + 1'b1;
              end
            end
          end else if (sample_en) begin
            hit_body_q  <= hit_body_q  | (head_active & body_active);
            hit_wall_q  <= hit_wall_q  | (head_active & border_active);
            hit_fruit_q <= hit_fruit_q | (head_active & fruit_active);
          end
        end

        GS_OVER: begin
          dir_q       <= DIR_IDLE;
          hit_body_q  <= 1'b0;
          hit_wall_q  <= 1'b0;
          hit_fruit_q <= 1'b0;
          if (frame_tick) begin
            if (hold_cnt_q == 8'd0) state_q <= GS_IDLE;
            else                    hold_cnt_q <= hold_cnt_q - 8'd1;
          end
        end

        default: state_q <= GS_IDLE;
      endcase
    end
  end

  assign game_state = state_q;
  assign direction  = dir_q;
  assign update     = update_q;
  assign eat        = eat_q;
  assign score      = score_q;

endmodule
